pipe_stall_ctrl: RTL and testbench
==================================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32, number of cycles the iterative divider is busy (legal range 2..63).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, maximum number of dmem wait cycles before abort (legal range 1..1023).
REQ-003 SHALL have port clk  in  1  clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports id_ra1 and id_ra2  in  5 each  ID-stage source register addresses.
REQ-006 SHALL have ports id_re1 and id_re2  in  1 each  ID-stage source read enables.
REQ-007 SHALL have ports ex_wa  in  5, ex_wreg  in  1, ex_mreg  in  1  EX-stage destination, write enable and load flag.
REQ-008 SHALL have port ex_div_start  in  1  DIV/DIVU instruction present in EX.
REQ-009 SHALL have ports dmem_req  in  1 (MEM-stage data access active) and dmem_ack  in  1 (data memory complete).
REQ-010 SHALL have port exc_flush  in  1  exception taken in MEM.
REQ-011 SHALL have port stall  out  5  freeze vector {memwb, exmem, idex, ifid, pc}, bit0 = pc.
REQ-012 SHALL have port flush  out  1  clear all pipeline registers to reset values.
REQ-013 SHALL have ports div_busy and div_done  out  1 each  divider status.
REQ-014 SHALL have port bus_err  out  1  single-cycle dmem timeout pulse.

Function
REQ-015 SHALL define bubble rule: the register just downstream of the highest set stall bit loads reset values; a set stall bit holds its register.
REQ-016 SHALL detect load-use when ex_mreg=1, ex_wreg=1, ex_wa!=0 and ex_wa matches an enabled id_ra1/id_ra2, and SHALL then output stall=5'b00011.
REQ-017 SHALL run a divider FSM with states IDLE, BUSY and DONE.
REQ-018 SHALL move IDLE->BUSY when ex_div_start=1 and exc_flush=0, loading a counter with DIV_CYCLES-1.
REQ-019 SHALL decrement the counter once per cycle in BUSY and move BUSY->DONE when the counter reaches 0 (DIV_CYCLES cycles after entry).
REQ-020 SHALL hold div_busy=1 in BUSY, and SHALL output stall=5'b00111 in BUSY and in the IDLE start cycle.
REQ-021 SHALL hold div_done=1 in DONE with the divide stall released, and SHALL move DONE->IDLE when no memory wait is pending; ex_div_start in DONE SHALL NOT restart the FSM.
REQ-022 SHALL treat memory wait as dmem_req=1 and dmem_ack=0, and SHALL output stall=5'b01111 during memory wait.
REQ-023 SHALL count memory-wait cycles; when the count reaches MEM_TIMEOUT it SHALL pulse bus_err for 1 cycle, release the stall that cycle and clear the count.
REQ-024 SHALL clear the wait count whenever dmem_ack=1 or dmem_req=0.
REQ-025 SHALL apply priority exc_flush > memory wait > divide > load-use; stall SHALL be 0 when none apply.
REQ-026 SHALL keep counting in BUSY during memory wait; reaching DONE during a wait SHALL hold DONE (div_done=1) until the wait ends.
REQ-027 SHALL, on exc_flush=1, drive flush=1 and stall=0 in the same cycle, force the FSM to IDLE on the next edge and clear both counters.
REQ-028 SHALL generate stall, flush and bus_err combinationally from registered state and current inputs; there is no extra latency.

Reset
REQ-029 SHALL, while rst_n=0, set FSM=IDLE, both counters=0, and force stall=0, flush=0, div_busy=0, div_done=0, bus_err=0.
REQ-030 SHALL abandon any divide or wait in progress on reset; no pending state survives reset.

Structure
REQ-031 SHALL place the stall-vector constants (NONE, LOADUSE, DIV, MEM), the FSM state encodings and the default parameter values in shared package cpu_pkg.
REQ-032 SHALL implement the divider FSM and counter as one sub-module, div_seq; hazard detection and priority muxing stay at top level.

Verification
REQ-033 SHALL test load-use: ex_mreg=1, ex_wreg=1, ex_wa=5, id_ra1=5, id_re1=1 -> stall=00011 for 1 cycle; repeat with ex_wa=0 -> stall=00000.
REQ-034 SHALL test divide: ex_div_start=1 with DIV_CYCLES=32 -> stall=00111 for cycles 0..32, div_done=1 at cycle 33 with stall=00000, IDLE at cycle 34.
REQ-035 SHALL test memory wait: dmem_req=1, dmem_ack=0 for 4 cycles then ack=1 -> stall=01111 for 4 cycles, then 00000, bus_err=0.
REQ-036 SHALL test timeout: MEM_TIMEOUT=8 and ack never arriving -> bus_err=1 exactly in the 8th wait cycle with stall=00000 that cycle.
REQ-037 SHALL test overlap: memory wait starting at BUSY cycle 30 and lasting 10 cycles -> div_done held high until the wait ends, stall=01111 throughout.
REQ-038 SHALL test flush mid-divide: exc_flush=1 at BUSY cycle 10 -> flush=1 and stall=00000 that cycle, div_busy=0 next cycle; also assert rst_n=0 mid-wait -> all outputs 0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the pipeline stall controller: stall vectors,
// divider FSM state encodings and default timing parameters.
package cpu_pkg;

  localparam int DIV_CYCLES_DEF  = 32;
  localparam int MEM_TIMEOUT_DEF = 255;

  // Freeze vector layout: {memwb, exmem, idex, ifid, pc}
  localparam logic [4:0] STALL_NONE    = 5'b00000;
  localparam logic [4:0] STALL_LOADUSE = 5'b00011;
  localparam logic [4:0] STALL_DIV     = 5'b00111;
  localparam logic [4:0] STALL_MEM     = 5'b01111;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_seq.sv
// Iterative-divider sequencer: tracks the busy window of a DIV/DIVU in EX
// and holds DONE until a concurrent memory wait has cleared.
module div_seq
  import cpu_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic flush_i,
  input  logic hold_i,
  output logic stall_o,
  output logic busy_o,
  output logic done_o
);

  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  div_state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_o = 1'b0;
    if (flush_i) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (start_i) begin
            state_d = DIV_BUSY;
            cnt_d   = DIV_LOAD;
            stall_o = 1'b1;
          end
        end
        DIV_BUSY: begin
          stall_o = 1'b1;
          if (cnt_q == 6'd0) state_d = DIV_DONE;
          else               cnt_d   = cnt_q - 6'd1;
        end
        DIV_DONE: begin
          // A new start here is the same instruction still in EX; ignore it.
          if (!hold_i) state_d = DIV_IDLE;
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q == DIV_BUSY);
  assign done_o = (state_q == DIV_DONE);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard controller: load-use detection, divider and memory-wait
// stalls, dmem timeout and exception flush, merged by fixed priority.
module pipe_stall_ctrl
  import cpu_pkg::*;
#(
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_ra1,
  input  logic [4:0] id_ra2,
  input  logic       id_re1,
  input  logic       id_re2,
  input  logic [4:0] ex_wa,
  input  logic       ex_wreg,
  input  logic       ex_mreg,
  input  logic       ex_div_start,
  input  logic       dmem_req,
  input  logic       dmem_ack,
  input  logic       exc_flush,
  output logic [4:0] stall,
  output logic       flush,
  output logic       div_busy,
  output logic       div_done,
  output logic       bus_err
);

  localparam logic [9:0] TO_LAST = 10'(MEM_TIMEOUT - 1);

  logic [9:0] wait_q, wait_d;
  logic       load_use, mem_wait, timeout, mem_stall, div_stall;

  assign load_use = ex_mreg && ex_wreg && (ex_wa != 5'd0) &&
                    ((id_re1 && (id_ra1 == ex_wa)) || (id_re2 && (id_ra2 == ex_wa)));
  assign mem_wait  = dmem_req && !dmem_ack;
  assign timeout   = mem_wait && (wait_q == TO_LAST);
  assign mem_stall = mem_wait && !timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end

  // The timeout cycle restarts the count so a still-stuck access aborts again.
  always_comb begin
    wait_d = wait_q + 10'd1;
    if (exc_flush || !mem_wait || timeout) wait_d = '0;
  end

  div_seq #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(ex_div_start),
    .flush_i(exc_flush),
    .hold_i (mem_stall),
    .stall_o(div_stall),
    .busy_o (div_busy),
    .done_o (div_done)
  );

  always_comb begin
    stall   = STALL_NONE;
    flush   = 1'b0;
    bus_err = 1'b0;
    if (rst_n) begin
      if (exc_flush) begin
        flush = 1'b1;
      end else begin
        bus_err = timeout;
        if (mem_stall)      stall = STALL_MEM;
        else if (div_stall) stall = STALL_DIV;
        else if (load_use)  stall = STALL_LOADUSE;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl; expected outputs are queued per step
// and compared against the selected instance shortly after inputs settle.
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_ra1, id_ra2, ex_wa;
  logic       id_re1, id_re2, ex_wreg, ex_mreg, ex_div_start;
  logic       dmem_req, dmem_ack, exc_flush;

  logic [4:0] stall, stall_t;
  logic       flush, div_busy, div_done, bus_err;
  logic       flush_t, div_busy_t, div_done_t, bus_err_t;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.DIV_CYCLES(32), .MEM_TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .id_ra1(id_ra1), .id_ra2(id_ra2),
    .id_re1(id_re1), .id_re2(id_re2), .ex_wa(ex_wa), .ex_wreg(ex_wreg),
    .ex_mreg(ex_mreg), .ex_div_start(ex_div_start), .dmem_req(dmem_req),
    .dmem_ack(dmem_ack), .exc_flush(exc_flush), .stall(stall), .flush(flush),
    .div_busy(div_busy), .div_done(div_done), .bus_err(bus_err)
  );

  pipe_stall_ctrl #(.DIV_CYCLES(32), .MEM_TIMEOUT(8)) dut_to (
    .clk(clk), .rst_n(rst_n), .id_ra1(id_ra1), .id_ra2(id_ra2),
    .id_re1(id_re1), .id_re2(id_re2), .ex_wa(ex_wa), .ex_wreg(ex_wreg),
    .ex_mreg(ex_mreg), .ex_div_start(ex_div_start), .dmem_req(dmem_req),
    .dmem_ack(dmem_ack), .exc_flush(exc_flush), .stall(stall_t), .flush(flush_t),
    .div_busy(div_busy_t), .div_done(div_done_t), .bus_err(bus_err_t)
  );

  typedef struct packed {
    logic       sel;
    logic [8:0] vec;  // {stall, flush, div_busy, div_done, bus_err}
  } exp_t;

  exp_t  sb[$];
  string tq[$];
  int    checks = 0;
  int    errors = 0;

  localparam logic [4:0] S0 = 5'b00000, SLU = 5'b00011, SDV = 5'b00111, SMW = 5'b01111;

  // Called just after a falling edge with inputs already driven.
  task automatic tick(input logic sel, input logic [4:0] st, input logic fl,
                      input logic bz, input logic dn, input logic be, input string tag);
    exp_t       e, x;
    string      t;
    logic [8:0] obs;
    e.sel = sel;
    e.vec = {st, fl, bz, dn, be};
    sb.push_back(e);
    tq.push_back(tag);
    #2;
    x = sb.pop_front();
    t = tq.pop_front();
    obs = x.sel ? {stall_t, flush_t, div_busy_t, div_done_t, bus_err_t}
                : {stall, flush, div_busy, div_done, bus_err};
    checks++;
    assert (obs === x.vec)
      else begin
        errors++;
        $error("FAIL %s: observed {stall,flush,busy,done,berr}=%b expected=%b", t, obs, x.vec);
      end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_ra1 = 5'd0; id_ra2 = 5'd0; id_re1 = 1'b0; id_re2 = 1'b0;
    ex_wa = 5'd0; ex_wreg = 1'b0; ex_mreg = 1'b0; ex_div_start = 1'b0;
    dmem_req = 1'b0; dmem_ack = 1'b0; exc_flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    // Reset must mask a live load-use, divide start and memory wait
    ex_mreg = 1'b1; ex_wreg = 1'b1; ex_wa = 5'd5; id_ra1 = 5'd5; id_re1 = 1'b1;
    ex_div_start = 1'b1; dmem_req = 1'b1;
    @(negedge clk);
    tick(1'b0, S0, 0, 0, 0, 0, "reset dut");
    tick(1'b1, S0, 0, 0, 0, 0, "reset dut_to");
    clear_inputs();
    rst_n = 1'b1;
    tick(1'b0, S0, 0, 0, 0, 0, "idle after reset");

    // Load-use
    ex_mreg = 1'b1; ex_wreg = 1'b1; ex_wa = 5'd5; id_ra1 = 5'd5; id_re1 = 1'b1;
    tick(1'b0, SLU, 0, 0, 0, 0, "loaduse ra1");
    ex_mreg = 1'b0;
    tick(1'b0, S0, 0, 0, 0, 0, "loaduse released");
    ex_mreg = 1'b1; ex_wa = 5'd0; id_ra1 = 5'd0;
    tick(1'b0, S0, 0, 0, 0, 0, "loaduse r0");
    ex_wa = 5'd5; id_ra1 = 5'd5; id_re1 = 1'b0;
    tick(1'b0, S0, 0, 0, 0, 0, "loaduse re1 off");
    id_ra2 = 5'd5; id_re2 = 1'b1;
    tick(1'b0, SLU, 0, 0, 0, 0, "loaduse ra2");
    clear_inputs();

    // Divide: start at cycle 0, done at 33, idle at 34
    ex_div_start = 1'b1;
    for (int i = 0; i <= 33; i++) begin
      if (i == 0)       tick(1'b0, SDV, 0, 0, 0, 0, $sformatf("div start c%0d", i));
      else if (i <= 32) tick(1'b0, SDV, 0, 1, 0, 0, $sformatf("div busy c%0d", i));
      else              tick(1'b0, S0,  0, 0, 1, 0, $sformatf("div done c%0d", i));
    end
    ex_div_start = 1'b0;
    tick(1'b0, S0, 0, 0, 0, 0, "div idle c34");

    // Memory wait of 4 cycles then ack
    dmem_req = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b0, SMW, 0, 0, 0, 0, $sformatf("memwait c%0d", i));
    dmem_ack = 1'b1;
    tick(1'b0, S0, 0, 0, 0, 0, "memwait ack");
    clear_inputs();
    tick(1'b0, S0, 0, 0, 0, 0, "memwait idle");

    // Overlap: wait during cycles 30..39 of a divide
    ex_div_start = 1'b1;
    for (int i = 0; i <= 40; i++) begin
      dmem_req = (i >= 30);
      dmem_ack = (i == 40);
      if (i == 0)       tick(1'b0, SDV, 0, 0, 0, 0, $sformatf("ovl c%0d", i));
      else if (i < 30)  tick(1'b0, SDV, 0, 1, 0, 0, $sformatf("ovl c%0d", i));
      else if (i <= 32) tick(1'b0, SMW, 0, 1, 0, 0, $sformatf("ovl c%0d", i));
      else if (i <= 39) tick(1'b0, SMW, 0, 0, 1, 0, $sformatf("ovl c%0d", i));
      else              tick(1'b0, S0,  0, 0, 1, 0, $sformatf("ovl c%0d", i));
    end
    clear_inputs();
    tick(1'b0, S0, 0, 0, 0, 0, "ovl idle");

    // Flush at cycle 10 of a divide
    ex_div_start = 1'b1;
    for (int i = 0; i < 10; i++)
      tick(1'b0, SDV, 0, (i != 0), 0, 0, $sformatf("flush pre c%0d", i));
    exc_flush = 1'b1;
    tick(1'b0, S0, 1, 1, 0, 0, "flush cycle");
    exc_flush = 1'b0; ex_div_start = 1'b0;
    tick(1'b0, S0, 0, 0, 0, 0, "after flush");

    // Asynchronous reset in the middle of a memory wait
    dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b0, SMW, 0, 0, 0, 0, $sformatf("rst pre c%0d", i));
    rst_n = 1'b0;
    tick(1'b0, S0, 0, 0, 0, 0, "reset mid-wait dut");
    tick(1'b1, S0, 0, 0, 0, 0, "reset mid-wait dut_to");
    dmem_req = 1'b0;
    rst_n = 1'b1;
    tick(1'b0, S0, 0, 0, 0, 0, "after reset");

    // Timeout with MEM_TIMEOUT=8 and no ack
    dmem_req = 1'b1;
    for (int i = 1; i <= 7; i++) tick(1'b1, SMW, 0, 0, 0, 0, $sformatf("timeout c%0d", i));
    tick(1'b1, S0, 0, 0, 0, 1, "timeout c8 berr");
    tick(1'b1, SMW, 0, 0, 0, 0, "timeout c9 rewait");
    dmem_req = 1'b0;
    tick(1'b1, S0, 0, 0, 0, 0, "timeout released");
    tick(1'b0, S0, 0, 0, 0, 0, "timeout long-limit dut");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
